// File: rtl/dp_sequencer.sv
// dp_sequencer: multi-cycle control FSM sequencing the ARM32 data-processing datapath
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   start, instr            instruction handshake; instr latched into IR when accepted in WAIT
//   status_in               NZCV flags {N,Z,C,V} used for the condition check in DECODE
//   waiting                 high only in WAIT
//   done, illegal           one-cycle pulses on the first WAIT cycle after retire/skip
//   rf_raddr                Rn in LOAD_A, Rm in LOAD_B, Rs in LOAD_S, else 0
//   en_A/en_B/en_S/en_C     operand/shift/result latch enables (LOAD_A/LOAD_B/LOAD_S/EXEC)
//   sel_imm, shift_src      B-operand source and register-specified shift select
//   alu_op                  IR[24:21]
//   w_en, wr_addr           register-file write in WB (not for TST/TEQ/CMP/CMN), Rd
//   load_status             status write in WB when the S bit is set
// Optional: define DP_SEQ_PERF_EN to add saturating retired_cnt/skipped_cnt outputs.
module dp_sequencer #(
    parameter int RF_AW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      instr,
    input  logic [3:0]       status_in,
    output logic             waiting,
    output logic             done,
    output logic             illegal,
    output logic [RF_AW-1:0] rf_raddr,
    output logic             en_A,
    output logic             en_B,
    output logic             en_S,
    output logic             en_C,
    output logic             sel_imm,
    output logic             shift_src,
    output logic [3:0]       alu_op,
    output logic             w_en,
    output logic [RF_AW-1:0] wr_addr,
    output logic             load_status
`ifdef DP_SEQ_PERF_EN
    ,
    output logic [15:0]      retired_cnt,
    output logic [15:0]      skipped_cnt
`endif
);
    typedef enum logic [2:0] {S_WAIT, S_DECODE, S_LOAD_A, S_LOAD_B, S_LOAD_S, S_EXEC, S_WB} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_ir;
    logic        r_done, r_illegal;
    logic        w_cond, w_skip, w_ill, w_retire, w_mov;
    logic        w_n, w_z, w_c, w_v;
    logic [3:0]  w_raddr;
    logic        w_unused;
    assign {w_n, w_z, w_c, w_v} = status_in;
    assign w_unused = ^r_ir[7:5];
    assign w_mov    = (r_ir[24:21] == 4'b1101) || (r_ir[24:21] == 4'b1111);
    assign w_retire = (r_state == S_WB);
    always_comb begin
        case (r_ir[31:28])
            4'h0:    w_cond = w_z;
            4'h1:    w_cond = !w_z;
            4'h2:    w_cond = w_c;
            4'h3:    w_cond = !w_c;
            4'h4:    w_cond = w_n;
            4'h5:    w_cond = !w_n;
            4'h6:    w_cond = w_v;
            4'h7:    w_cond = !w_v;
            4'h8:    w_cond = w_c && !w_z;
            4'h9:    w_cond = !w_c || w_z;
            4'hA:    w_cond = (w_n == w_v);
            4'hB:    w_cond = (w_n != w_v);
            4'hC:    w_cond = !w_z && (w_n == w_v);
            4'hD:    w_cond = w_z || (w_n != w_v);
            4'hE:    w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end
    always_comb begin
        w_next = r_state;
        w_skip = 1'b0;
        w_ill  = 1'b0;
        case (r_state)
            S_WAIT:   w_next = start ? S_DECODE : S_WAIT;
            S_DECODE: begin
                // a failed condition wins over the illegal check: nothing executes either way
                if (!w_cond) begin
                    w_next = S_WAIT;
                    w_skip = 1'b1;
                end else if (r_ir[27:26] != 2'b00) begin
                    w_next = S_WAIT;
                    w_skip = 1'b1;
                    w_ill  = 1'b1;
                end else begin
                    w_next = w_mov ? S_LOAD_B : S_LOAD_A;
                end
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = shift_src ? S_LOAD_S : S_EXEC;
            S_LOAD_S: w_next = S_EXEC;
            S_EXEC:   w_next = S_WB;
            S_WB:     w_next = S_WAIT;
            default:  w_next = S_WAIT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_WAIT;
            r_ir      <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            if (r_state == S_WAIT && start) r_ir <= instr;
            // registered so done/illegal stay pure functions of the state registers
            r_done    <= w_skip || w_retire;
            r_illegal <= w_ill;
        end
    end
    assign w_raddr     = (r_state == S_LOAD_A) ? r_ir[19:16] :
                         (r_state == S_LOAD_B) ? r_ir[3:0]   :
                         (r_state == S_LOAD_S) ? r_ir[11:8]  : 4'h0;
    assign rf_raddr    = RF_AW'(w_raddr);
    assign waiting     = (r_state == S_WAIT);
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign en_A        = (r_state == S_LOAD_A);
    assign en_B        = (r_state == S_LOAD_B);
    assign en_S        = (r_state == S_LOAD_S);
    assign en_C        = (r_state == S_EXEC);
    assign sel_imm     = r_ir[25];
    assign shift_src   = !r_ir[25] && r_ir[4];
    assign alu_op      = r_ir[24:21];
    // TST/TEQ/CMP/CMN (10xx) only update flags
    assign w_en        = w_retire && (r_ir[24:23] != 2'b10);
    assign wr_addr     = RF_AW'(r_ir[15:12]);
    assign load_status = w_retire && r_ir[20];
`ifdef DP_SEQ_PERF_EN
    logic [15:0] r_retired, r_skipped;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
            r_skipped <= '0;
        end else begin
            if (w_retire && r_retired != 16'hFFFF) r_retired <= r_retired + 16'd1;
            if (w_skip && r_skipped != 16'hFFFF) r_skipped <= r_skipped + 16'd1;
        end
    end
    assign retired_cnt = r_retired;
    assign skipped_cnt = r_skipped;
`endif
endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: directed self-checking bench for dp_sequencer
module tb_dp_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] instr = '0;
    logic [3:0]  status_in = '0;
    logic        waiting, done, illegal, en_A, en_B, en_S, en_C, sel_imm, shift_src, w_en, load_status;
    logic [3:0]  rf_raddr, alu_op, wr_addr;
`ifdef DP_SEQ_PERF_EN
    logic [15:0] retired_cnt, skipped_cnt;
`endif
    int vec = 0;
    int err = 0;
    // per-instruction trace, filled by issue()
    int na, nb, ns, nc, nw, nls, ndone, nill, wait_at, done_at;
    logic [3:0] ra_a, ra_b, ra_s, wa;
    logic       simm, ssrc;
    logic [3:0] op;
    logic [3:0] cc_tab [8] = '{4'hC, 4'hA, 4'h8, 4'h9, 4'hF, 4'h1, 4'h4, 4'h7};
    logic [3:0] fl_tab [8] = '{4'b1000, 4'b1001, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b1000, 4'b0000};
    int         ok_tab [8] = '{0, 1, 1, 0, 0, 0, 1, 1};

    dp_sequencer #(.RF_AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .status_in(status_in),
        .waiting(waiting), .done(done), .illegal(illegal), .rf_raddr(rf_raddr),
        .en_A(en_A), .en_B(en_B), .en_S(en_S), .en_C(en_C), .sel_imm(sel_imm),
        .shift_src(shift_src), .alu_op(alu_op), .w_en(w_en), .wr_addr(wr_addr),
        .load_status(load_status)
`ifdef DP_SEQ_PERF_EN
        , .retired_cnt(retired_cnt), .skipped_cnt(skipped_cnt)
`endif
    );

    always #5 clk = ~clk;

    // wait_at: edges after the accept edge until waiting; done_at: edges including the accept edge
    task automatic issue(input logic [31:0] ins, input logic [3:0] st);
        @(negedge clk);
        start = 1'b1; instr = ins; status_in = st;
        @(negedge clk);
        start = 1'b0; instr = '0;
        na = 0; nb = 0; ns = 0; nc = 0; nw = 0; nls = 0; ndone = 0; nill = 0;
        wait_at = -1; done_at = -1;
        ra_a = 'x; ra_b = 'x; ra_s = 'x; wa = 'x;
        simm = sel_imm; ssrc = shift_src; op = alu_op;
        for (int k = 0; k < 20; k++) begin
            if (en_A) begin na++; ra_a = rf_raddr; end
            if (en_B) begin nb++; ra_b = rf_raddr; end
            if (en_S) begin ns++; ra_s = rf_raddr; end
            if (en_C) nc++;
            if (w_en) begin nw++; wa = wr_addr; end
            if (load_status) nls++;
            if (illegal) nill++;
            if (done) begin ndone++; if (done_at < 0) done_at = k + 1; end
            if (waiting) begin wait_at = k; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        vec++; if (waiting !== 1'b1) begin err++; $display("FAIL reset_waiting got %b exp 1", waiting); end
        vec++; if ({done, illegal, en_A, en_B, en_S, en_C, w_en, load_status} !== 8'h00) begin
            err++; $display("FAIL reset_ctrl got %b exp 00000000", {done, illegal, en_A, en_B, en_S, en_C, w_en, load_status}); end
        vec++; if ({rf_raddr, alu_op, wr_addr, sel_imm, shift_src} !== 14'h0) begin
            err++; $display("FAIL reset_decode got %h exp 0", {rf_raddr, alu_op, wr_addr, sel_imm, shift_src}); end
    endtask

    task automatic test_add_reg;
        issue(32'hE0800000, 4'h0);
        vec++; if (wait_at !== 5) begin err++; $display("FAIL add_latency got %0d exp 5", wait_at); end
        vec++; if (na !== 1 || ra_a !== 4'd0) begin err++; $display("FAIL add_load_a got n=%0d a=%h exp n=1 a=0", na, ra_a); end
        vec++; if (nb !== 1 || ra_b !== 4'd0) begin err++; $display("FAIL add_load_b got n=%0d a=%h exp n=1 a=0", nb, ra_b); end
        vec++; if (ns !== 0 || nc !== 1) begin err++; $display("FAIL add_s_c got s=%0d c=%0d exp s=0 c=1", ns, nc); end
        vec++; if (nw !== 1 || wa !== 4'd0 || nls !== 0) begin err++; $display("FAIL add_wb got w=%0d rd=%h ls=%0d exp 1 0 0", nw, wa, nls); end
        vec++; if (ndone !== 1 || nill !== 0) begin err++; $display("FAIL add_done got d=%0d i=%0d exp 1 0", ndone, nill); end
        issue(32'hE0465007, 4'h0);
        vec++; if (ra_a !== 4'd6 || ra_b !== 4'd7 || wa !== 4'd5) begin
            err++; $display("FAIL sub_regs got rn=%h rm=%h rd=%h exp 6 7 5", ra_a, ra_b, wa); end
        vec++; if (op !== 4'h2 || wait_at !== 5) begin err++; $display("FAIL sub_op got op=%h lat=%0d exp 2 5", op, wait_at); end
    endtask

    task automatic test_reg_shift;
        issue(32'hE0822210, 4'h0);
        vec++; if (wait_at !== 6) begin err++; $display("FAIL rs_latency got %0d exp 6", wait_at); end
        vec++; if (ns !== 1 || ra_s !== 4'd2) begin err++; $display("FAIL rs_load_s got n=%0d a=%h exp 1 2", ns, ra_s); end
        vec++; if (ssrc !== 1'b1 || simm !== 1'b0) begin err++; $display("FAIL rs_src got ss=%b si=%b exp 1 0", ssrc, simm); end
        vec++; if (ra_a !== 4'd2 || ra_b !== 4'd0 || wa !== 4'd2 || nw !== 1) begin
            err++; $display("FAIL rs_regs got rn=%h rm=%h rd=%h w=%0d exp 2 0 2 1", ra_a, ra_b, wa, nw); end
    endtask

    task automatic test_mov_imm;
        issue(32'hE3A03005, 4'h0);
        vec++; if (wait_at !== 4) begin err++; $display("FAIL mov_latency got %0d exp 4", wait_at); end
        vec++; if (na !== 0 || nb !== 1 || ra_b !== 4'd5) begin err++; $display("FAIL mov_loads got a=%0d b=%0d rm=%h exp 0 1 5", na, nb, ra_b); end
        vec++; if (simm !== 1'b1 || ssrc !== 1'b0 || op !== 4'hD) begin
            err++; $display("FAIL mov_decode got si=%b ss=%b op=%h exp 1 0 d", simm, ssrc, op); end
        vec++; if (nw !== 1 || wa !== 4'd3) begin err++; $display("FAIL mov_wb got w=%0d rd=%h exp 1 3", nw, wa); end
    endtask

    task automatic test_cmp;
        issue(32'hE1500001, 4'h0);
        vec++; if (nw !== 0 || nls !== 1) begin err++; $display("FAIL cmp_wb got w=%0d ls=%0d exp 0 1", nw, nls); end
        vec++; if (op !== 4'hA || wait_at !== 5) begin err++; $display("FAIL cmp_op got op=%h lat=%0d exp a 5", op, wait_at); end
    endtask

    task automatic test_cond;
        issue(32'h00800000, 4'b0000);
        vec++; if (done_at !== 2 || ndone !== 1) begin err++; $display("FAIL eq_skip_done got at=%0d n=%0d exp 2 1", done_at, ndone); end
        vec++; if (na !== 0 || nb !== 0 || nw !== 0 || nill !== 0) begin
            err++; $display("FAIL eq_skip_quiet got a=%0d b=%0d w=%0d i=%0d exp 0 0 0 0", na, nb, nw, nill); end
        issue(32'h00800000, 4'b0100);
        vec++; if (wait_at !== 5 || nw !== 1) begin err++; $display("FAIL eq_taken got lat=%0d w=%0d exp 5 1", wait_at, nw); end
        for (int i = 0; i < 8; i++) begin
            issue({cc_tab[i], 28'h0800000}, fl_tab[i]);
            vec++; if (nw !== ok_tab[i] || ndone !== 1) begin
                err++; $display("FAIL cond_%h_%b got w=%0d d=%0d exp %0d 1", cc_tab[i], fl_tab[i], nw, ndone, ok_tab[i]); end
        end
    endtask

    task automatic test_illegal;
        issue(32'hE5900000, 4'h0);
        vec++; if (done_at !== 2 || nill !== 1 || ndone !== 1) begin
            err++; $display("FAIL ill_pulse got at=%0d i=%0d d=%0d exp 2 1 1", done_at, nill, ndone); end
        vec++; if (na !== 0 || nb !== 0 || nw !== 0) begin err++; $display("FAIL ill_quiet got a=%0d b=%0d w=%0d exp 0 0 0", na, nb, nw); end
        issue(32'h05900000, 4'h0);
        vec++; if (nill !== 0 || ndone !== 1) begin err++; $display("FAIL ill_condfail got i=%0d d=%0d exp 0 1", nill, ndone); end
    endtask

    task automatic test_reset_midflight;
        int k;
        @(negedge clk);
        start = 1'b1; instr = 32'hE0800000; status_in = 4'h0;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 10 && !en_C; k++) @(negedge clk);
        vec++; if (en_C !== 1'b1) begin err++; $display("FAIL mid_reach_exec got %b exp 1", en_C); end
        #2 rst_n = 1'b0;
        #1;
        vec++; if (waiting !== 1'b1 || w_en !== 1'b0 || en_C !== 1'b0 || done !== 1'b0) begin
            err++; $display("FAIL mid_async got wt=%b we=%b ec=%b d=%b exp 1 0 0 0", waiting, w_en, en_C, done); end
        @(negedge clk);
        vec++; if (w_en !== 1'b0 || load_status !== 1'b0) begin err++; $display("FAIL mid_hold got we=%b ls=%b exp 0 0", w_en, load_status); end
        rst_n = 1'b1;
        issue(32'hE0800000, 4'h0);
        vec++; if (wait_at !== 5 || nw !== 1) begin err++; $display("FAIL mid_next got lat=%0d w=%0d exp 5 1", wait_at, nw); end
    endtask

    task automatic test_back_to_back;
        int k;
        @(negedge clk);
        start = 1'b1; instr = 32'hE0465007; status_in = 4'h0;
        @(negedge clk);
        instr = 32'hE3A03005;
        wa = 'x;
        for (k = 0; k < 12 && !waiting; k++) begin
            if (w_en) wa = wr_addr;
            @(negedge clk);
        end
        vec++; if (k !== 5 || wa !== 4'd5) begin err++; $display("FAIL b2b_first got lat=%0d rd=%h exp 5 5", k, wa); end
        vec++; if (done !== 1'b1) begin err++; $display("FAIL b2b_done got %b exp 1", done); end
        @(negedge clk);
        start = 1'b0;
        vec++; if (waiting !== 1'b0) begin err++; $display("FAIL b2b_reaccept got %b exp 0", waiting); end
        wa = 'x; na = 0;
        for (k = 0; k < 12 && !waiting; k++) begin
            if (w_en) wa = wr_addr;
            if (en_A) na++;
            @(negedge clk);
        end
        vec++; if (k !== 4 || wa !== 4'd3 || na !== 0) begin
            err++; $display("FAIL b2b_second got lat=%0d rd=%h a=%0d exp 4 3 0", k, wa, na); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_add_reg;
        test_reg_shift;
        test_mov_imm;
        test_cmp;
        test_cond;
        test_illegal;
        test_reset_midflight;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
